// File: rtl/remora_frame_ctrl_if.sv
// rtl/remora_frame_ctrl_if.sv - SPI frame buffer bundle between the SPI slave and the frame controller
interface remora_frame_ctrl_if #(
    parameter int BUFFER_SIZE = 240
);
    logic                   pkg_ok;
    logic [BUFFER_SIZE-1:0] rx_data;
    logic [BUFFER_SIZE-1:0] tx_data;

    modport master (output pkg_ok, output rx_data, input tx_data);
    modport slave  (input pkg_ok, input rx_data, output tx_data);
endinterface

// File: rtl/remora_frame_ctrl.sv
// rtl/remora_frame_ctrl.sv - command/feedback frame controller with watchdog and fault gating
module remora_frame_ctrl #(
    parameter int                 NUM_JOINTS     = 5,
    parameter int                 NUM_VOUTS      = 2,
    parameter int                 NUM_VINS       = 2,
    parameter int                 NUM_DOUT       = 6,
    parameter int                 NUM_DIN        = 5,
    parameter int                 BUFFER_SIZE    = 240,
    parameter int unsigned        TIMEOUT_CYCLES = 100000,
    parameter logic [NUM_DOUT-1:0] DOUT_SAFE     = '0,
    parameter bit                 STICKY_FAULT   = 1'b0
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    remora_frame_ctrl_if.slave      spi,
    input  logic [32*NUM_JOINTS-1:0] joint_feedback,
    input  logic [16*NUM_VINS-1:0]   process_variable,
    input  logic [NUM_DIN-1:0]       din,
    output logic [32*NUM_JOINTS-1:0] joint_freq_cmd,
    output logic [16*NUM_VOUTS-1:0]  set_point,
    output logic [NUM_JOINTS-1:0]    joint_enable,
    output logic [NUM_DOUT-1:0]      dout,
    output logic                     ena,
    output logic                     error,
    output logic [15:0]              bad_frames
);
    localparam logic [31:0] HDR_WRITE = 32'h7772_6974;
    localparam logic [31:0] HDR_READ  = 32'h7265_6164;
    localparam logic [31:0] HDR_DATA  = 32'h6461_7461;
    localparam logic [31:0] TMO       = TIMEOUT_CYCLES;

    // Bit offsets from the MSB of the frame buffer
    localparam int RX_SP   = 32 + 32*NUM_JOINTS;
    localparam int RX_EN   = RX_SP + 16*NUM_VOUTS;
    localparam int RX_BITS = RX_EN + 16;
    localparam int TX_PV   = 32 + 32*NUM_JOINTS;
    localparam int TX_DIN  = TX_PV + 16*NUM_VINS;
    localparam int TX_BITS = TX_DIN + 16;
    localparam int LAYOUT_BITS = (RX_BITS > TX_BITS) ? RX_BITS : TX_BITS;

    if (BUFFER_SIZE < LAYOUT_BITS) begin : g_size_check
        $error("remora_frame_ctrl: BUFFER_SIZE smaller than frame layout");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    state_t                   state, state_nxt;
    logic                     pkg_ok_q;
    logic [31:0]              wdog, wdog_nxt;
    logic [15:0]              bad_nxt;
    logic [31:0]              rx_hdr;
    logic                     frame_evt, is_write, is_read, is_bad, feed, timeout, run_nxt;
    logic [7:0]               en_byte, dout_byte, din_byte;
    logic [32*NUM_JOINTS-1:0] freq_lat, freq_nxt;
    logic [NUM_JOINTS-1:0]    en_lat, en_nxt;
    logic [NUM_DOUT-1:0]      dout_lat, dout_nxt;
    logic [16*NUM_VOUTS-1:0]  sp_nxt;
    logic                     ena_nxt, err_nxt;
    logic [BUFFER_SIZE-1:0]   tx_nxt;
    logic                     rx_unused;

    assign rx_unused = ^spi.rx_data;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            pkg_ok_q       <= 1'b0;
            wdog           <= '0;
            bad_frames     <= '0;
            joint_freq_cmd <= '0;
            joint_enable   <= '0;
            set_point      <= '0;
            dout           <= DOUT_SAFE;
            ena            <= 1'b0;
            error          <= 1'b0;
            spi.tx_data    <= '0;
        end else begin
            state          <= state_nxt;
            pkg_ok_q       <= spi.pkg_ok;
            wdog           <= wdog_nxt;
            bad_frames     <= bad_nxt;
            joint_freq_cmd <= freq_nxt;
            joint_enable   <= en_nxt;
            set_point      <= sp_nxt;
            dout           <= dout_nxt;
            ena            <= ena_nxt;
            error          <= err_nxt;
            spi.tx_data    <= tx_nxt;
        end
    end

    always_comb begin
        frame_evt = spi.pkg_ok & ~pkg_ok_q;
        rx_hdr    = swap32(spi.rx_data[BUFFER_SIZE-1 -: 32]);
        is_write  = frame_evt && (rx_hdr == HDR_WRITE);
        is_read   = frame_evt && (rx_hdr == HDR_READ);
        is_bad    = frame_evt && !is_write && !is_read;
        feed      = is_write || is_read;
        timeout   = (wdog == TMO);

        // A feed in the timeout cycle keeps the link alive
        state_nxt = state;
        case (state)
            ST_IDLE:  if (is_write) state_nxt = ST_RUN;
            ST_RUN:   if (!feed && timeout) state_nxt = ST_FAULT;
            ST_FAULT: if (is_write && !STICKY_FAULT) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase

        wdog_nxt = feed ? 32'd0 : (timeout ? wdog : wdog + 32'd1);
        bad_nxt  = (is_bad && bad_frames != 16'hFFFF) ? bad_frames + 16'd1 : bad_frames;

        freq_lat  = joint_freq_cmd;
        en_lat    = joint_enable;
        dout_lat  = dout;
        sp_nxt    = set_point;
        en_byte   = spi.rx_data[BUFFER_SIZE-1-RX_EN -: 8];
        dout_byte = spi.rx_data[BUFFER_SIZE-1-RX_EN-8 -: 8];
        if (is_write) begin
            for (int i = 0; i < NUM_JOINTS; i++) begin
                freq_lat[32*i +: 32] = swap32(spi.rx_data[BUFFER_SIZE-1-32-32*i -: 32]);
                en_lat[i]            = en_byte[7-i];
            end
            for (int i = 0; i < NUM_VOUTS; i++)
                sp_nxt[16*i +: 16] = swap16(spi.rx_data[BUFFER_SIZE-1-RX_SP-16*i -: 16]);
            dout_lat = dout_byte[NUM_DOUT-1:0];
        end

        run_nxt  = (state_nxt == ST_RUN);
        freq_nxt = run_nxt ? freq_lat : '0;
        en_nxt   = run_nxt ? en_lat : '0;
        dout_nxt = run_nxt ? dout_lat : DOUT_SAFE;
        ena_nxt  = run_nxt && (|en_lat);
        err_nxt  = (state_nxt == ST_FAULT);

        din_byte                 = '0;
        din_byte[NUM_DIN-1:0]    = din;
        tx_nxt                   = '0;
        tx_nxt[BUFFER_SIZE-1 -: 32] = swap32(err_nxt ? 32'd0 : HDR_DATA);
        for (int i = 0; i < NUM_JOINTS; i++)
            tx_nxt[BUFFER_SIZE-1-32-32*i -: 32] = swap32(joint_feedback[32*i +: 32]);
        for (int i = 0; i < NUM_VINS; i++)
            tx_nxt[BUFFER_SIZE-1-TX_PV-16*i -: 16] = swap16(process_variable[16*i +: 16]);
        tx_nxt[BUFFER_SIZE-1-TX_DIN -: 8] = din_byte;
    end
endmodule

// File: tb/tb_remora_frame_ctrl.sv
// tb/tb_remora_frame_ctrl.sv - scoreboard bench for remora_frame_ctrl
module tb_remora_frame_ctrl;
    localparam int NJ = 5, NV = 2, NVI = 2, ND = 6, NDI = 5, BS = 240;
    localparam logic [ND-1:0] DSAFE = 6'h2A;
    localparam logic [31:0] H_W = 32'h77726974, H_R = 32'h72656164, H_D = 32'h64617461;
    localparam logic [31:0] H_BAD = 32'hDEADBEEF;
    localparam int F_FREQ = 0, F_JEN = 1, F_ENA = 2, F_ERR = 3, F_DOUT = 4, F_BAD = 5,
                   F_SP = 6, F_TXHDR = 7, F_TXB = 8, F_WDOG = 9;

    typedef struct {
        int          due;
        int          dut;
        int          fld;
        int          arg;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic                rst_n;
    logic [32*NJ-1:0]    jfb;
    logic [16*NVI-1:0]   pv;
    logic [NDI-1:0]      din;
    logic [32*NJ-1:0]    fq   [2];
    logic [16*NV-1:0]    spv  [2];
    logic [NJ-1:0]       jen  [2];
    logic [ND-1:0]       dov  [2];
    logic                enav [2];
    logic                errv [2];
    logic [15:0]         badv [2];

    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t sbq[$];

    remora_frame_ctrl_if #(.BUFFER_SIZE(BS)) ifa ();
    remora_frame_ctrl_if #(.BUFFER_SIZE(BS)) ifb ();
    assign ifb.pkg_ok  = ifa.pkg_ok;
    assign ifb.rx_data = ifa.rx_data;

    remora_frame_ctrl #(.NUM_JOINTS(NJ), .NUM_VOUTS(NV), .NUM_VINS(NVI), .NUM_DOUT(ND),
        .NUM_DIN(NDI), .BUFFER_SIZE(BS), .TIMEOUT_CYCLES(100), .DOUT_SAFE(DSAFE),
        .STICKY_FAULT(1'b0)) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .spi(ifa.slave), .joint_feedback(jfb),
        .process_variable(pv), .din(din), .joint_freq_cmd(fq[0]), .set_point(spv[0]),
        .joint_enable(jen[0]), .dout(dov[0]), .ena(enav[0]), .error(errv[0]),
        .bad_frames(badv[0]));

    remora_frame_ctrl #(.NUM_JOINTS(NJ), .NUM_VOUTS(NV), .NUM_VINS(NVI), .NUM_DOUT(ND),
        .NUM_DIN(NDI), .BUFFER_SIZE(BS), .TIMEOUT_CYCLES(100), .DOUT_SAFE(DSAFE),
        .STICKY_FAULT(1'b1)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .spi(ifb.slave), .joint_feedback(jfb),
        .process_variable(pv), .din(din), .joint_freq_cmd(fq[1]), .set_point(spv[1]),
        .joint_enable(jen[1]), .dout(dov[1]), .ena(enav[1]), .error(errv[1]),
        .bad_frames(badv[1]));

    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [BS-1:0] put(input logic [BS-1:0] f, input int pos,
                                          input logic [31:0] v, input int n);
        for (int b = 0; b < n; b++) f[BS-1-pos-8*b -: 8] = v[8*b +: 8];
        return f;
    endfunction

    function automatic logic [BS-1:0] mk(input logic [31:0] hdr, input logic [31:0] c0,
                                         input logic [31:0] c1, input logic [15:0] sp0,
                                         input logic [7:0] en, input logic [7:0] dq);
        logic [BS-1:0] f;
        f = '0;
        f = put(f, 0, hdr, 4);
        f = put(f, 32, c0, 4);
        f = put(f, 64, c1, 4);
        f = put(f, 192, {16'h0, sp0}, 2);
        f = put(f, 224, {24'h0, en}, 1);
        f = put(f, 232, {24'h0, dq}, 1);
        return f;
    endfunction

    function automatic logic [31:0] get_act(input int d, input int f, input int a);
        logic [BS-1:0] tx;
        tx = (d == 0) ? ifa.tx_data : ifb.tx_data;
        case (f)
            F_FREQ:  return fq[d][32*a +: 32];
            F_JEN:   return 32'(jen[d]);
            F_ENA:   return 32'(enav[d]);
            F_ERR:   return 32'(errv[d]);
            F_DOUT:  return 32'(dov[d]);
            F_BAD:   return 32'(badv[d]);
            F_SP:    return 32'(spv[d][16*a +: 16]);
            F_TXHDR: return {tx[BS-25 -: 8], tx[BS-17 -: 8], tx[BS-9 -: 8], tx[BS-1 -: 8]};
            F_TXB:   return 32'(tx[BS-1-8*a -: 8]);
            F_WDOG:  return (d == 0) ? dut_a.wdog : dut_b.wdog;
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic chk(input int d, input int f, input int a, input logic [31:0] e,
                       input string nm, input int dly);
        exp_t x;
        x.due = cyc + dly; x.dut = d; x.fld = f; x.arg = a; x.exp = e; x.name = nm;
        sbq.push_back(x);
    endtask

    task automatic chk2(input int f, input int a, input logic [31:0] e, input string nm,
                        input int dly);
        chk(0, f, a, e, nm, dly);
        chk(1, f, a, e, nm, dly);
    endtask

    always @(negedge sysclk) begin : monitor
        int   i;
        logic [31:0] act;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due <= cyc) begin
                act = get_act(sbq[i].dut, sbq[i].fld, sbq[i].arg);
                n_total++;
                if (sbq[i].due < cyc || act !== sbq[i].exp) begin
                    n_bad++;
                    $display("FAIL %s dut%0d cyc=%0d: got %h want %h", sbq[i].name,
                             sbq[i].dut, cyc, act, sbq[i].exp);
                end
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic drive_frame(input logic [BS-1:0] f);
        @(negedge sysclk);
        ifa.rx_data = f;
        ifa.pkg_ok  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sysclk);
            ifa.pkg_ok = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL sim_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        logic [BS-1:0] badf;
        badf = mk(H_BAD, 32'h9999, 32'h9999, 16'h9999, 8'hFF, 8'hFF);
        rst_n = 1'b0; ifa.pkg_ok = 1'b0; ifa.rx_data = '0;
        jfb = '0; jfb[31:0] = 32'h11223344; pv = {16'h0000, 16'hBEEF}; din = 5'b10101;

        idle(1);
        chk2(F_ERR, 0, 0, "rst_error", 1);
        chk2(F_ENA, 0, 0, "rst_ena", 1);
        chk2(F_BAD, 0, 0, "rst_bad", 1);
        chk2(F_DOUT, 0, 32'(DSAFE), "rst_dout", 1);
        chk2(F_FREQ, 0, 0, "rst_freq0", 1);
        chk2(F_TXHDR, 0, 0, "rst_txhdr", 1);
        idle(2);
        rst_n = 1'b1;
        chk2(F_TXHDR, 0, H_D, "idle_txhdr", 1);
        chk(0, F_TXB, 4, 32'h44, "tx_fb_b0", 1);
        chk(0, F_TXB, 5, 32'h33, "tx_fb_b1", 1);
        chk(0, F_TXB, 6, 32'h22, "tx_fb_b2", 1);
        chk(0, F_TXB, 7, 32'h11, "tx_fb_b3", 1);
        chk(0, F_TXB, 24, 32'hEF, "tx_pv_b0", 1);
        chk(0, F_TXB, 25, 32'hBE, "tx_pv_b1", 1);
        chk(0, F_TXB, 28, 32'h15, "tx_din", 1);
        chk(0, F_TXB, 29, 32'h00, "tx_pad", 1);
        idle(3);

        drive_frame(mk(H_W, 32'h0000_1000, 32'hFFFF_FFF0, 16'h1234, 8'h80, 8'h3C));
        chk2(F_FREQ, 0, 32'h1000, "wr_freq0", 1);
        chk2(F_FREQ, 1, 32'hFFFF_FFF0, "wr_freq1", 1);
        chk2(F_JEN, 0, 32'h01, "wr_jen", 1);
        chk2(F_ENA, 0, 1, "wr_ena", 1);
        chk2(F_DOUT, 0, 32'h3C, "wr_dout", 1);
        chk2(F_SP, 0, 32'h1234, "wr_sp0", 1);
        chk2(F_TXHDR, 0, H_D, "wr_txhdr", 1);
        idle(5);
        n_total++;
        if (fq[0][31:0] !== 32'h0000_1000) begin
            n_bad++;
            $display("FAIL direct_wr_freq0: got %h want %h", fq[0][31:0], 32'h0000_1000);
        end
        n_total++;
        if (enav[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_wr_ena: got %b want 1", enav[0]);
        end
        n_total++;
        if (dov[0] !== 6'h3C) begin
            n_bad++;
            $display("FAIL direct_wr_dout: got %h want 3c", dov[0]);
        end

        drive_frame(mk(H_R, 32'h5555, 32'h6666, 16'h9999, 8'h00, 8'h00));
        chk2(F_FREQ, 0, 32'h1000, "rd_freq0", 1);
        chk2(F_SP, 0, 32'h1234, "rd_sp0", 1);
        chk2(F_JEN, 0, 32'h01, "rd_jen", 1);
        chk2(F_WDOG, 0, 0, "rd_wdog", 1);
        chk2(F_BAD, 0, 0, "rd_bad", 1);
        idle(2);

        for (int k = 1; k <= 3; k++) begin
            drive_frame(badf);
            chk2(F_BAD, 0, 32'(k), "bad_count", 1);
            chk2(F_FREQ, 0, 32'h1000, "bad_nolatch", 1);
            idle(1);
        end
        idle(1);
        force dut_a.bad_frames = 16'hFFFF;
        idle(1);
        release dut_a.bad_frames;
        drive_frame(badf);
        chk(0, F_BAD, 0, 32'hFFFF, "bad_sat", 1);
        chk(1, F_BAD, 0, 32'd4, "bad_count4", 1);
        idle(1);

        drive_frame(mk(H_W, 32'h0000_3000, 32'h0, 16'h5678, 8'hC0, 8'h0F));
        chk2(F_FREQ, 0, 32'h3000, "w2_freq0", 1);
        chk2(F_JEN, 0, 32'h03, "w2_jen", 1);
        chk2(F_DOUT, 0, 32'h0F, "w2_dout", 1);
        chk(0, F_BAD, 0, 32'hFFFF, "held_bad", 4);
        chk(1, F_BAD, 0, 32'd4, "held_bad", 4);
        chk2(F_FREQ, 0, 32'h3000, "held_freq0", 4);
        chk2(F_WDOG, 0, 100, "to_wdog_lim", 101);
        chk2(F_ERR, 0, 0, "to_err_before", 101);
        chk2(F_ERR, 0, 1, "to_err", 102);
        chk2(F_ENA, 0, 0, "to_ena", 102);
        chk2(F_FREQ, 0, 0, "to_freq0", 102);
        chk2(F_JEN, 0, 0, "to_jen", 102);
        chk2(F_DOUT, 0, 32'(DSAFE), "to_dout", 102);
        chk2(F_TXHDR, 0, 0, "to_txhdr", 102);
        chk2(F_SP, 0, 32'h5678, "to_sp0", 102);
        chk2(F_WDOG, 0, 100, "to_wdog_sat", 150);
        @(negedge sysclk); ifa.rx_data = badf;
        repeat (2) @(negedge sysclk);
        idle(150);

        drive_frame(mk(H_W, 32'h0000_2000, 32'h0, 16'h0ABC, 8'h40, 8'h01));
        chk(0, F_ERR, 0, 0, "rec_err", 1);
        chk(0, F_ENA, 0, 1, "rec_ena", 1);
        chk(0, F_FREQ, 0, 32'h2000, "rec_freq0", 1);
        chk(0, F_JEN, 0, 32'h02, "rec_jen", 1);
        chk(0, F_DOUT, 0, 32'h01, "rec_dout", 1);
        chk(0, F_TXHDR, 0, H_D, "rec_txhdr", 1);
        chk(1, F_ERR, 0, 1, "sticky_err", 1);
        chk(1, F_ENA, 0, 0, "sticky_ena", 1);
        chk(1, F_FREQ, 0, 0, "sticky_freq0", 1);
        chk(1, F_DOUT, 0, 32'(DSAFE), "sticky_dout", 1);
        chk(1, F_TXHDR, 0, 0, "sticky_txhdr", 1);
        chk2(F_SP, 0, 32'h0ABC, "rec_sp0", 1);
        chk(0, F_WDOG, 0, 100, "race_wdog_lim", 101);
        idle(100);
        drive_frame(mk(H_R, 32'h1, 32'h1, 16'h1, 8'h00, 8'h00));
        chk(0, F_ERR, 0, 0, "race_err", 1);
        chk(0, F_WDOG, 0, 0, "race_wdog", 1);
        chk(0, F_FREQ, 0, 32'h2000, "race_freq0", 1);
        chk(0, F_ERR, 0, 0, "race_err_late", 3);
        chk(1, F_ERR, 0, 1, "race_sticky", 1);
        idle(4);

        @(negedge sysclk);
        rst_n = 1'b0;
        ifa.rx_data = mk(H_W, 32'h7777, 32'h7777, 16'h7777, 8'hFF, 8'hFF);
        ifa.pkg_ok = 1'b1;
        chk2(F_FREQ, 0, 0, "mrst_freq0", 1);
        chk2(F_ENA, 0, 0, "mrst_ena", 1);
        chk2(F_ERR, 0, 0, "mrst_err", 1);
        chk2(F_BAD, 0, 0, "mrst_bad", 1);
        chk2(F_DOUT, 0, 32'(DSAFE), "mrst_dout", 1);
        chk2(F_WDOG, 0, 0, "mrst_wdog", 1);
        chk2(F_TXHDR, 0, 0, "mrst_txhdr", 1);
        idle(1);
        rst_n = 1'b1;
        chk2(F_ENA, 0, 0, "post_rst_ena", 2);
        chk2(F_TXHDR, 0, H_D, "post_rst_txhdr", 2);
        idle(4);
        n_total++;
        if (errv[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_post_rst_err: got %b want 0", errv[0]);
        end
        n_total++;
        if (ifa.tx_data[BS-1 -: 8] !== 8'h61) begin
            n_bad++;
            $display("FAIL direct_post_rst_txb0: got %h want 61", ifa.tx_data[BS-1 -: 8]);
        end

        while (sbq.size() > 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s dut%0d: got unchecked want checked at cyc %0d", sbq[0].name,
                     sbq[0].dut, sbq[0].due);
            void'(sbq.pop_front());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/remora_frame_ctrl.md
# remora_frame_ctrl

Parametrised command/feedback frame controller between the SPI slave and the motion peripherals (stepgens, PWMs, digital I/O). It edge-detects `pkg_ok`, validates the 32-bit RX header, latches command fields only from valid frames, and builds the registered TX frame. A watchdog and a three-state fault machine force all outputs to a safe state on link loss or bad traffic. Channel counts, timeout and fault policy are parameters.

## Interface
- `NUM_JOINTS`, 5, stepgen channels (1..8).
- `NUM_VOUTS`, 2, 16-bit setpoint channels (0..8).
- `NUM_VINS`, 2, 16-bit process-variable channels (0..8).
- `NUM_DOUT`, 6, digital outputs (1..8).
- `NUM_DIN`, 5, digital inputs (1..8).
- `BUFFER_SIZE`, 240, SPI frame bits. Must be ≥ max(RX, TX layout); elaboration error otherwise.
- `TIMEOUT_CYCLES`, 100000, idle `sysclk` cycles before timeout.
- `DOUT_SAFE`, 0, value of `dout` in safe state.
- `STICKY_FAULT`, 0, when 1 only reset leaves FAULT.
- `sysclk` in 1 — system clock; sole clock domain.
- `rst_n` in 1 — synchronous, active-low reset.
- `pkg_ok` in 1 — SPI frame complete (level; rising edge used).
- `rx_data` in BUFFER_SIZE — received frame.
- `tx_data` out BUFFER_SIZE — frame to transmit.
- `joint_feedback` in 32*NUM_JOINTS — signed step positions, ch0 at LSBs.
- `process_variable` in 16*NUM_VINS — analog feedback.
- `din` in NUM_DIN — digital inputs.
- `joint_freq_cmd` out 32*NUM_JOINTS — signed frequency commands.
- `set_point` out 16*NUM_VOUTS — PWM duties.
- `joint_enable` out NUM_JOINTS — per-joint enable.
- `dout` out NUM_DOUT — digital outputs.
- `ena` out 1 — OR of `joint_enable`, gated by no-fault.
- `error` out 1 — high in FAULT.
- `bad_frames` out 16 — saturating count of rejected frames.

## Operation
- Frame layout, MSB-first, each multi-byte field little-endian on the wire (field LSB byte at highest buffer position).
  - RX: header32, NUM_JOINTS×cmd32, NUM_VOUTS×sp16, enable byte (bit7 = joint0), dout byte (bit0 = dout0). Remaining LSBs ignored.
  - TX: header32, NUM_JOINTS×fb32, NUM_VINS×pv16, din byte (bit0 = din0, unused bits 0), pad byte 0x00. Unused LSBs 0.
- Frame event: `pkg_ok & ~pkg_ok_q`.
  - Header 0x77726974 ("writ") = WRITE.
  - Header 0x72656164 ("read") = READ.
  - Anything else = BAD.
- WRITE: latch all command fields and feed the watchdog.
- READ: feed the watchdog only; commands hold.
- BAD: no latch, no feed; `bad_frames`+1, saturating at 0xFFFF.
- Watchdog: 32-bit counter, cleared by a feed, otherwise +1, saturating at TIMEOUT_CYCLES. Timeout = counter == TIMEOUT_CYCLES.
- States:
  - IDLE (after reset): outputs safe. First WRITE → RUN.
  - RUN: timeout → FAULT.
  - FAULT: outputs safe. With STICKY_FAULT=0, a WRITE → RUN; with STICKY_FAULT=1, stays until reset.
- Safe outputs: `joint_freq_cmd`=0, `joint_enable`=0, `ena`=0, `dout`=DOUT_SAFE. `set_point` keeps its latched value but is unused, since `ena`=0.
- Leaving IDLE/FAULT takes the values of the same WRITE frame.
- TX header: 0x64617461 ("data") when not FAULT, else 0x00000000. Feedback fields are always live.
- Reset values: all command registers 0, `dout`=DOUT_SAFE, `error`=0 (IDLE is not a fault), `bad_frames`=0, watchdog 0, `tx_data`=0, `pkg_ok_q`=0.

## Timing
- Edge at cycle N: latched commands, state and `bad_frames` are visible at N+1.
- `tx_data` is registered: inputs at cycle N appear at N+1.
- A frame event and timeout in the same cycle: the feed wins. Counter → 0, no FAULT entry.
- `pkg_ok` held high: one event only. A new event needs a low cycle first.
- Reset asserted mid-operation: takes effect at the next edge, all state to reset values, the pending edge is discarded.
- A pkg_ok edge in the same cycle as `rst_n`=0 is discarded.
- `ena`, `error` and safe gating are registered and change in the same cycle as the state.

## Test plan
- Reset, then WRITE with cmd0=0x00001000 and enable=0x80 → at N+1 `joint_freq_cmd[31:0]`=0x1000, `joint_enable[0]`=1, `ena`=1, TX header 0x64617461.
- READ with different cmd bytes → commands unchanged, watchdog cleared, `bad_frames`=0.
- Header 0xDEADBEEF, three times → no latch, `bad_frames`=3. Saturation forced at 0xFFFF stays 0xFFFF.
- No frames for TIMEOUT_CYCLES (bench override 100) after RUN → `error`=1, `ena`=0, cmds 0, `dout`=DOUT_SAFE, TX header 0. Next WRITE with STICKY_FAULT=0 → RUN. With STICKY_FAULT=1 → stays FAULT.
- Frame edge on the exact cycle the counter reaches limit → no FAULT.
- `joint_feedback[31:0]`=0x11223344 → TX bytes after header are 0x44,0x33,0x22,0x11. `din`=5'b10101 → din byte 0x15.
